// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with a word-wide TX FIFO.
//
// Each FIFO word holds BYTE_WIDTH bytes, and the bytes are sent as separate
// characters. The frame format is latched per character when it is loaded:
// the baud divisor, 5-8 data bits, parity none/odd/even and 1 or 2 stop bits.
// Optional CTS gating is checked only between words.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   baud_div    clk cycles per bit (0 and 1 are treated as 2)
//   data_bits   0..3 -> 5..8 data bits
//   parity      00/11 none, 01 odd, 10 even
//   stop2       1: two stop bits
//   cts_n       clear-to-send, active-low, asynchronous (used when CTS_EN=1)
//   wreq/wgnt   FIFO write request and same-cycle grant
//   wdata       FIFO write word
//   fifo_level  number of words stored
//   busy        controller not idle
//   frame_done  one-cycle pulse in the last cycle of each character
//   o_uart_tx   serial output, idle high
module uart_tx_cfg #(
  parameter int unsigned CLK_DIV_W  = 16,
  parameter int unsigned FIFO_ASIZE = 9,
  parameter int unsigned BYTE_WIDTH = 1,
  parameter int unsigned BIG_ENDIAN = 0,
  parameter int unsigned CTS_EN     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CLK_DIV_W-1:0]    baud_div,
  input  logic [1:0]              data_bits,
  input  logic [1:0]              parity,
  input  logic                    stop2,
  input  logic                    cts_n,
  input  logic                    wreq,
  output logic                    wgnt,
  input  logic [BYTE_WIDTH*8-1:0] wdata,
  output logic [FIFO_ASIZE-1:0]   fifo_level,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    o_uart_tx
);

  localparam int unsigned WordW = BYTE_WIDTH * 8;
  localparam int unsigned Depth = 1 << FIFO_ASIZE;
  localparam int unsigned IdxW  = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [WordW-1:0]      mem [Depth];
  logic [WordW-1:0]      rdata_q;
  logic [FIFO_ASIZE-1:0] wr_ptr_q, rd_ptr_q;
  logic                  full, empty, pop;

  // One slot is sacrificed so that full and empty are distinguishable.
  assign full       = (wr_ptr_q + FIFO_ASIZE'(1)) == rd_ptr_q;
  assign empty      = wr_ptr_q == rd_ptr_q;
  assign wgnt       = wreq & ~full;
  assign fifo_level = wr_ptr_q - rd_ptr_q;

  // The RAM is not reset, and its contents are discarded through the pointers.
  always_ff @(posedge clk) begin
    if (wgnt) begin
      mem[wr_ptr_q] <= wdata;
    end
    if (pop) begin
      rdata_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wgnt) begin
        wr_ptr_q <= wr_ptr_q + FIFO_ASIZE'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_ASIZE'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CTS synchroniser (resets to "not clear")
  // ---------------------------------------------------------------------------
  logic [1:0] cts_sync_q;
  logic       cts_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_sync_q <= 2'b11;
    end else begin
      cts_sync_q <= {cts_sync_q[0], cts_n};
    end
  end

  assign cts_ok = (CTS_EN == 0) || !cts_sync_q[1];

  // ---------------------------------------------------------------------------
  // Byte lane selection within the popped word
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]      byte_sel;
  logic            last_byte;

  always_comb begin
    byte_sel = rdata_q[7:0];
    for (int unsigned i = 0; i < BYTE_WIDTH; i++) begin
      if (byte_idx_q == IdxW'((BIG_ENDIAN != 0) ? (BYTE_WIDTH - 1 - i) : i)) begin
        byte_sel = rdata_q[i*8 +: 8];
      end
    end
  end

  assign last_byte = byte_idx_q == IdxW'(BYTE_WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Transmit controller
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [CLK_DIV_W-1:0] timer_q, timer_d;
  logic [CLK_DIV_W-1:0] bitp_q, bitp_d;
  logic [CLK_DIV_W-1:0] bitp_in;
  logic [1:0]           data_bits_q, data_bits_d;
  logic [1:0]           parity_q, parity_d;
  logic                 stop2_q, stop2_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 par_q, par_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 tick, par_en, par_bit, last_data;

  assign bitp_in   = (baud_div < CLK_DIV_W'(2)) ? CLK_DIV_W'(2) : baud_div;
  assign tick      = timer_q == '0;
  assign par_en    = (parity_q == 2'b01) || (parity_q == 2'b10);
  // par_q accumulates the XOR of the sent data bits, so even parity is the XOR itself.
  assign par_bit   = (parity_q == 2'b10) ? par_q : ~par_q;
  assign last_data = bit_cnt_q == (3'(data_bits_q) + 3'd4);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bitp_d      = bitp_q;
    data_bits_d = data_bits_q;
    parity_d    = parity_q;
    stop2_d     = stop2_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    par_d       = par_q;
    stop_cnt_d  = stop_cnt_q;
    byte_idx_d  = byte_idx_q;
    tx_d        = tx_q;
    pop         = 1'b0;
    frame_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty && cts_ok) begin
          pop     = 1'b1;
          state_d = StFetch;
        end
      end

      StFetch: begin
        byte_idx_d = '0;
        state_d    = StLoad;
      end

      // The character format is frozen here, so later input changes
      // only apply to the next character.
      StLoad: begin
        bitp_d      = bitp_in;
        data_bits_d = data_bits;
        parity_d    = parity;
        stop2_d     = stop2;
        shreg_d     = byte_sel;
        timer_d     = bitp_in - CLK_DIV_W'(1);
        bit_cnt_d   = '0;
        par_d       = 1'b0;
        stop_cnt_d  = 1'b0;
        tx_d        = 1'b0;
        state_d     = StStart;
      end

      StStart: begin
        if (tick) begin
          timer_d = bitp_q - CLK_DIV_W'(1);
          tx_d    = shreg_q[0];
          par_d   = par_q ^ shreg_q[0];
          shreg_d = shreg_q >> 1;
          state_d = StData;
        end else begin
          timer_d = timer_q - CLK_DIV_W'(1);
        end
      end

      StData: begin
        if (tick) begin
          timer_d = bitp_q - CLK_DIV_W'(1);
          if (last_data) begin
            if (par_en) begin
              tx_d    = par_bit;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shreg_q[0];
            par_d     = par_q ^ shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end else begin
          timer_d = timer_q - CLK_DIV_W'(1);
        end
      end

      StParity: begin
        if (tick) begin
          timer_d = bitp_q - CLK_DIV_W'(1);
          tx_d    = 1'b1;
          state_d = StStop;
        end else begin
          timer_d = timer_q - CLK_DIV_W'(1);
        end
      end

      StStop: begin
        if (tick) begin
          if (stop2_q && !stop_cnt_q) begin
            timer_d    = bitp_q - CLK_DIV_W'(1);
            stop_cnt_d = 1'b1;
          end else begin
            frame_done = 1'b1;
            // Remaining bytes of a word go out without a CTS check.
            if (!last_byte) begin
              byte_idx_d = byte_idx_q + IdxW'(1);
              state_d    = StLoad;
            end else begin
              state_d = StIdle;
            end
          end
        end else begin
          timer_d = timer_q - CLK_DIV_W'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      bitp_q      <= CLK_DIV_W'(2);
      data_bits_q <= 2'b11;
      parity_q    <= 2'b00;
      stop2_q     <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      stop_cnt_q  <= 1'b0;
      byte_idx_q  <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bitp_q      <= bitp_d;
      data_bits_q <= data_bits_d;
      parity_q    <= parity_d;
      stop2_q     <= stop2_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      stop_cnt_q  <= stop_cnt_d;
      byte_idx_q  <= byte_idx_d;
      tx_q        <= tx_d;
    end
  end

  assign busy      = state_q != StIdle;
  assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg. It uses three instances:
//   0: default parameters (1-byte words, no CTS)
//   1: 3-bit FIFO, 2-byte little-endian words, CTS honoured
//   2: 2-byte big-endian words
// When a word is written, the expected frames are queued. A line monitor
// then decodes the selected instance cycle by cycle and checks every bit's
// value and exact duration, the inter-character gap and frame_done.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] baud_div;
  logic [1:0]  data_bits, parity;
  logic        stop2, cts_n;
  logic [15:0] wdata;
  logic        wreq0, wreq1, wreq2;
  logic        wgnt0, wgnt1, wgnt2;
  logic [8:0]  lvl0, lvl2;
  logic [2:0]  lvl1;
  logic        busy0, busy1, busy2;
  logic        fd0, fd1, fd2;
  logic        tx0, tx1, tx2;

  always #5 clk = ~clk;

  uart_tx_cfg u_dut0 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .data_bits(data_bits), .parity(parity),
    .stop2(stop2), .cts_n(cts_n), .wreq(wreq0), .wgnt(wgnt0), .wdata(wdata[7:0]),
    .fifo_level(lvl0), .busy(busy0), .frame_done(fd0), .o_uart_tx(tx0)
  );

  uart_tx_cfg #(.FIFO_ASIZE(3), .BYTE_WIDTH(2), .BIG_ENDIAN(0), .CTS_EN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .data_bits(data_bits), .parity(parity),
    .stop2(stop2), .cts_n(cts_n), .wreq(wreq1), .wgnt(wgnt1), .wdata(wdata),
    .fifo_level(lvl1), .busy(busy1), .frame_done(fd1), .o_uart_tx(tx1)
  );

  uart_tx_cfg #(.BYTE_WIDTH(2), .BIG_ENDIAN(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .data_bits(data_bits), .parity(parity),
    .stop2(stop2), .cts_n(cts_n), .wreq(wreq2), .wgnt(wgnt2), .wdata(wdata),
    .fifo_level(lvl2), .busy(busy2), .frame_done(fd2), .o_uart_tx(tx2)
  );

  int   sel = 0;
  logic line, fd_sel, busy_sel, wgnt_sel;
  assign line     = (sel == 1) ? tx1 : (sel == 2) ? tx2 : tx0;
  assign fd_sel   = (sel == 1) ? fd1 : (sel == 2) ? fd2 : fd0;
  assign busy_sel = (sel == 1) ? busy1 : (sel == 2) ? busy2 : busy0;
  assign wgnt_sel = (sel == 1) ? wgnt1 : (sel == 2) ? wgnt2 : wgnt0;

  typedef struct {
    logic [11:0] bits;  // line values, start bit first
    int          nb;
    int          bitp;
    int          gap;   // required idle-high cycles before the start bit, -1: don't care
  } frame_t;

  frame_t sb[$];
  int     n_pass = 0;
  int     n_total = 0;
  int     done_cnt = 0;
  int     gap_cnt = -1;
  bit     mon_en = 1'b0;
  bit     mon_busy = 1'b0;
  bit     mon_abort = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input logic [1:0] db,
                                        input logic [1:0] par, input logic s2,
                                        input int baud, input int gap);
    frame_t f;
    int     k;
    logic   x;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    k = 1;
    x = 1'b0;
    for (int i = 0; i < int'(db) + 5; i++) begin
      f.bits[k] = d[i];
      x ^= d[i];
      k++;
    end
    if (par == 2'b01) begin
      f.bits[k] = ~x;
      k++;
    end else if (par == 2'b10) begin
      f.bits[k] = x;
      k++;
    end
    k += s2 ? 2 : 1;
    f.nb   = k;
    f.bitp = (baud < 2) ? 2 : baud;
    f.gap  = gap;
    return f;
  endfunction

  task automatic add(input logic [7:0] d, input int gap);
    sb.push_back(make_frame(d, data_bits, parity, stop2, int'(baud_div), gap));
  endtask

  task automatic set_wreq(input logic v);
    if (sel == 1) wreq1 = v;
    else if (sel == 2) wreq2 = v;
    else wreq0 = v;
  endtask

  // Single-word write. On return, the write edge k has just passed (time k+1).
  task automatic write_word(input logic [15:0] d);
    @(posedge clk);
    #1;
    wdata = d;
    set_wreq(1'b1);
    @(negedge clk);
    check("wgnt", wgnt_sel, 1);
    @(posedge clk);
    #1;
    set_wreq(1'b0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || mon_busy || busy_sel) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < budget, 1);
  endtask

  always @(negedge clk) if (fd_sel === 1'b1) done_cnt++;

  // Line monitor
  initial begin : monitor
    frame_t e;
    bit     ok, fdv, aborted;
    forever begin
      @(negedge clk);
      if (mon_abort) begin
        mon_abort = 1'b0;
        gap_cnt   = -1;
        continue;
      end
      if (!mon_en || line !== 1'b0) begin
        if (gap_cnt >= 0) gap_cnt++;
        continue;
      end
      check("frame_expected", sb.size() > 0, 1);
      if (sb.size() == 0) begin
        while (line === 1'b0 && !mon_abort) @(negedge clk);
        gap_cnt = -1;
        continue;
      end
      e        = sb.pop_front();
      mon_busy = 1'b1;
      if (e.gap >= 0) check("char_gap", gap_cnt, e.gap);
      aborted = 1'b0;
      fdv     = 1'b0;
      for (int b = 0; b < e.nb && !aborted; b++) begin
        ok = 1'b1;
        for (int c = 0; c < e.bitp; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (mon_abort) begin
            aborted = 1'b1;
            break;
          end
          if (line !== e.bits[b]) ok = 1'b0;
          if (b == e.nb - 1 && c == e.bitp - 1) fdv = fd_sel;
        end
        if (!aborted) check($sformatf("line_bit%0d", b), ok, 1);
      end
      if (aborted) begin
        mon_abort = 1'b0;
        gap_cnt   = -1;
      end else begin
        check("frame_done_last_cycle", fdv, 1);
        gap_cnt = 0;
      end
      mon_busy = 1'b0;
    end
  end

  initial begin : main
    int          d0;
    int          n;
    logic [15:0] w;
    baud_div  = 16'd10;
    data_bits = 2'd3;
    parity    = 2'b00;
    stop2     = 1'b0;
    cts_n     = 1'b1;
    wdata     = '0;
    wreq0     = 1'b0;
    wreq1     = 1'b0;
    wreq2     = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_tx", tx0, 1);
    check("rst_level", lvl0, 0);
    check("rst_busy", busy0, 0);
    check("rst_frame_done", fd0, 0);
    check("rst_wgnt_idle", wgnt0, 0);
    check("rst_level1", lvl1, 0);
    wreq0 = 1'b1;
    #1 check("rst_wgnt_follows", wgnt0, 1);
    wreq0 = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // 8N1 at baud 10, 0x41: latency, busy span, one frame_done
    d0 = done_cnt;
    add(8'h41, -1);
    write_word(16'h0041);
    @(negedge clk);
    check("busy_before_pop", busy0, 0);
    check("level_one", lvl0, 1);
    @(negedge clk);
    check("busy_after_pop", busy0, 1);
    check("level_after_pop", lvl0, 0);
    @(negedge clk);
    check("start_not_early", tx0, 1);
    @(negedge clk);
    check("start_edge", tx0, 0);
    repeat (99) @(negedge clk);
    check("busy_last_cycle", busy0, 1);
    @(negedge clk);
    check("busy_end", busy0, 0);
    wait_idle("idle_8n1", 500);
    check("done_count_8n1", done_cnt - d0, 1);

    // 7 data bits, two stop bits, even then odd parity
    d0 = done_cnt;
    baud_div  = 16'd4;
    data_bits = 2'd2;
    parity    = 2'b10;
    stop2     = 1'b1;
    add(8'h55, -1);
    write_word(16'h0055);
    wait_idle("idle_7e2", 500);
    parity = 2'b01;
    add(8'h55, -1);
    write_word(16'h0055);
    wait_idle("idle_7o2", 500);
    check("done_count_parity", done_cnt - d0, 2);

    // Baud change mid-character applies only to the next character
    d0 = done_cnt;
    baud_div  = 16'd10;
    data_bits = 2'd3;
    parity    = 2'b00;
    stop2     = 1'b0;
    add(8'hA5, -1);
    write_word(16'h00A5);
    sb.push_back(make_frame(8'h3C, 2'd3, 2'b00, 1'b0, 20, 3));
    write_word(16'h003C);
    repeat (10) @(posedge clk);
    #1 baud_div = 16'd20;
    wait_idle("idle_baud_change", 1000);
    check("done_count_baud", done_cnt - d0, 2);

    // Big-endian word: high byte first, one-cycle gap between the characters
    sel      = 2;
    baud_div = 16'd4;
    add(8'h12, -1);
    add(8'h34, 1);
    write_word(16'h1234);
    wait_idle("idle_big_endian", 500);

    // CTS held off: fill the 7-word FIFO, then release
    sel       = 1;
    d0        = done_cnt;
    data_bits = 2'd3;
    parity    = 2'b10;
    w         = 16'h1234;
    @(posedge clk);
    #1;
    wdata = w;
    wreq1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("cts_fill_wgnt", wgnt1, 1);
      add(w[7:0], (i == 0) ? -1 : 3);
      add(w[15:8], 1);
      @(posedge clk);
      #1;
      w     = 16'($urandom);
      wdata = w;
    end
    @(negedge clk);
    check("full_wgnt", wgnt1, 0);
    check("full_level", lvl1, 7);
    check("cts_blocks_tx", busy1, 0);
    @(posedge clk);
    #1 cts_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("cts_sync_delay", wgnt1, 0);
    n = 0;
    while (wgnt1 !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("wgnt_reassert", (n >= 1 && n <= 3), 1);
    check("busy_after_cts", busy1, 1);
    add(w[7:0], 3);
    add(w[15:8], 1);
    @(posedge clk);
    #1 wreq1 = 1'b0;
    wait_idle("idle_cts", 3000);
    check("done_count_cts", done_cnt - d0, 16);
    check("level_drained", lvl1, 0);
    cts_n = 1'b1;

    // Reset during data bit 3
    sel       = 0;
    baud_div  = 16'd10;
    parity    = 2'b00;
    add(8'hA5, -1);
    write_word(16'h00A5);
    write_word(16'h003C);
    repeat (45) @(posedge clk);
    #2;
    check("pre_reset_bit3", tx0, 0);
    check("pre_reset_level", lvl0, 1);
    mon_abort = 1'b1;
    sb.delete();
    rst_n = 1'b0;
    #1;
    check("reset_line_high", tx0, 1);
    check("reset_level", lvl0, 0);
    check("reset_busy", busy0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = done_cnt;
    repeat (150) @(negedge clk);
    check("post_reset_line", tx0, 1);
    check("post_reset_no_frames", done_cnt - d0, 0);
    check("post_reset_busy", busy0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
